// File: rtl/aes_display_pager_if.sv
// Block-transfer channel from the AES core into the display pager.
// The master drives the block and its valid flag; the pager answers with ready.
interface aes_display_pager_if;
  logic [0:127] i_block;
  logic         i_block_valid;
  logic         o_block_ready;

  modport master (output i_block, output i_block_valid, input o_block_ready);
  modport slave  (input i_block, input i_block_valid, output o_block_ready);
endinterface

// File: rtl/aes_display_pager.sv
// Holds one 128-bit AES result and shows it 16 bits at a time on a display,
// stepping pages on request or on a dwell timer, with a refresh strobe per change.
module aes_display_pager #(
  parameter logic [31:0] DWELL_CYCLES = 32'd100_000_000
) (
  input  logic                 clk,
  input  logic                 clr,
  aes_display_pager_if.slave   blk_if,
  input  logic                 i_next,
  input  logic                 i_auto_en,
  output logic [0:15]          o_data,
  output logic                 o_refresh,
  output logic [2:0]           o_page,
  output logic [0:31]          o_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_e;

  state_e       state_q, state_d;
  logic [0:127] buf_q, buf_d;
  logic [2:0]   page_q, page_d;
  logic [31:0]  dwell_q, dwell_d;
  logic [0:31]  count_q, count_d;
  logic         refresh_q, refresh_d;

  logic handshake;
  logic expire;
  logic advance;

  assign blk_if.o_block_ready = (state_q != LOAD);
  assign handshake = blk_if.i_block_valid && (state_q != LOAD);
  assign expire    = i_auto_en && (dwell_q == DWELL_CYCLES - 32'd1);
  assign advance   = (state_q == SHOW) && (i_next || expire);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    page_d    = page_q;
    dwell_d   = dwell_q;
    count_d   = count_q;
    refresh_d = 1'b0;
    // A new block wins over any advance arriving in the same cycle.
    if (handshake) begin
      buf_d     = blk_if.i_block;
      page_d    = 3'd0;
      dwell_d   = 32'd0;
      count_d   = count_q + 32'd1;
      refresh_d = 1'b1;
      state_d   = LOAD;
    end else begin
      case (state_q)
        LOAD: state_d = SHOW;
        SHOW: begin
          if (advance) begin
            page_d    = page_q + 3'd1;
            dwell_d   = 32'd0;
            refresh_d = 1'b1;
          end else if (i_auto_en) begin
            dwell_d = dwell_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      page_q    <= 3'd0;
      dwell_q   <= 32'd0;
      count_q   <= '0;
      refresh_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      page_q    <= page_d;
      dwell_q   <= dwell_d;
      count_q   <= count_d;
      refresh_q <= refresh_d;
    end
  end

  // Refresh is registered alongside page_q so data and strobe change together.
  assign o_data    = (state_q == IDLE) ? 16'h0000 : buf_q[{page_q, 4'b0000} +: 16];
  assign o_refresh = refresh_q;
  assign o_page    = page_q;
  assign o_count   = count_q;

endmodule

// File: tb/tb_aes_display_pager.sv
// Scoreboard bench for aes_display_pager: each refresh-causing stimulus queues the
// page/data/count it should produce; every observed o_refresh pops one entry.
module tb_aes_display_pager;

  logic        clk;
  logic        clr;
  logic        i_next;
  logic        i_auto_en;
  logic [0:15] o_data;
  logic        o_refresh;
  logic [2:0]  o_page;
  logic [0:31] o_count;

  aes_display_pager_if bus ();

  aes_display_pager #(.DWELL_CYCLES(32'd4)) dut (
    .clk       (clk),
    .clr       (clr),
    .blk_if    (bus),
    .i_next    (i_next),
    .i_auto_en (i_auto_en),
    .o_data    (o_data),
    .o_refresh (o_refresh),
    .o_page    (o_page),
    .o_count   (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  page;
    logic [31:0] count;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] blk_m;
  int           page_m;
  logic [31:0]  cnt_m;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] BLK_C = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  // Page 0 is the most significant 16 bits of the block.
  function automatic logic [15:0] page_word(input logic [127:0] b, input int p);
    logic [127:0] s;
    s = b >> (112 - 16 * p);
    return s[15:0];
  endfunction

  function automatic exp_t make_exp(input logic [127:0] b, input int p, input logic [31:0] c);
    exp_t e;
    e.data  = page_word(b, p);
    e.page  = 3'(p);
    e.count = c;
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard consumer: one line per observed refresh.
  always @(negedge clk) begin
    if (o_refresh === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_refresh: got refresh page=%0d data=%h, required no pulse", o_page, o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_data !== e.data || o_page !== e.page || o_count !== e.count) begin
          n_bad++;
          $display("FAIL sb_refresh: got data=%h page=%0d count=%h, required data=%h page=%0d count=%h",
                   o_data, o_page, o_count, e.data, e.page, e.count);
        end else begin
          $display("refresh page=%0d data=%h count=%0d", o_page, o_data, o_count);
        end
      end
    end
  end

  task automatic test_reset();
    clr = 1'b1; i_next = 1'b0; i_auto_en = 1'b0;
    bus.i_block = '0; bus.i_block_valid = 1'b0;
    step(); step();
    clr = 1'b0;
    blk_m = '0; page_m = 0; cnt_m = 32'd0;
    n_cmp++; if (o_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h required 0000", o_data); end
    n_cmp++; if (o_page !== 3'd0) begin n_bad++; $display("FAIL reset_page: got %0d required 0", o_page); end
    n_cmp++; if (o_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %h required 0", o_count); end
    n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL reset_refresh: got %b required 0", o_refresh); end
    n_cmp++; if (bus.o_block_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", bus.o_block_ready); end
  endtask

  task automatic test_idle();
    i_next = 1'b1; i_auto_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL idle_refresh: got %b required 0 (cycle %0d)", o_refresh, k); end
      n_cmp++; if (o_data !== 16'h0000) begin n_bad++; $display("FAIL idle_data: got %h required 0000 (cycle %0d)", o_data, k); end
    end
    i_next = 1'b0; i_auto_en = 1'b0;
    step();
  endtask

  task automatic test_load(input logic [127:0] b);
    n_cmp++; if (bus.o_block_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_before: got %b required 1", bus.o_block_ready); end
    bus.i_block = b; bus.i_block_valid = 1'b1;
    cnt_m = cnt_m + 32'd1; blk_m = b; page_m = 0;
    exp_q.push_back(make_exp(b, 0, cnt_m));
    step();
    bus.i_block_valid = 1'b0;
    n_cmp++; if (o_refresh !== 1'b1) begin n_bad++; $display("FAIL load_refresh: got %b required 1", o_refresh); end
    n_cmp++; if (o_data !== page_word(b, 0)) begin n_bad++; $display("FAIL load_data: got %h required %h", o_data, page_word(b, 0)); end
    n_cmp++; if (o_page !== 3'd0) begin n_bad++; $display("FAIL load_page: got %0d required 0", o_page); end
    n_cmp++; if (o_count !== cnt_m) begin n_bad++; $display("FAIL load_count: got %h required %h", o_count, cnt_m); end
    n_cmp++; if (bus.o_block_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready: got %b required 0", bus.o_block_ready); end
    step();
    n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL load_refresh_after: got %b required 0", o_refresh); end
    n_cmp++; if (bus.o_block_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_after: got %b required 1", bus.o_block_ready); end
  endtask

  task automatic test_manual(input int pulses);
    for (int k = 0; k < pulses; k++) begin
      i_next = 1'b1;
      page_m = (page_m + 1) % 8;
      exp_q.push_back(make_exp(blk_m, page_m, cnt_m));
      step();
      i_next = 1'b0;
      n_cmp++; if (o_refresh !== 1'b1) begin n_bad++; $display("FAIL manual_refresh: got %b required 1 (pulse %0d)", o_refresh, k); end
      n_cmp++; if (o_data !== page_word(blk_m, page_m)) begin n_bad++; $display("FAIL manual_data: got %h required %h", o_data, page_word(blk_m, page_m)); end
      step();
      n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL manual_single_pulse: got %b required 0 (pulse %0d)", o_refresh, k); end
    end
  endtask

  task automatic test_auto();
    i_auto_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k % 4 == 0 && k <= 12) begin
        page_m = (page_m + 1) % 8;
        exp_q.push_back(make_exp(blk_m, page_m, cnt_m));
      end
      step();
      n_cmp++;
      if (o_refresh !== ((k % 4 == 0 && k <= 12) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL auto_period: got refresh=%b at show cycle %0d", o_refresh, k);
      end
    end
    // Dwell counter now holds 2; freeze it for 10 cycles.
    i_auto_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL auto_freeze: got refresh=%b required 0 (cycle %0d)", o_refresh, k); end
    end
    i_auto_en = 1'b1;
    step();
    n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL auto_resume_early: got refresh=%b required 0", o_refresh); end
    page_m = (page_m + 1) % 8;
    exp_q.push_back(make_exp(blk_m, page_m, cnt_m));
    step();
    i_auto_en = 1'b0;
    n_cmp++; if (o_refresh !== 1'b1) begin n_bad++; $display("FAIL auto_resume: got refresh=%b required 1 (count lost)", o_refresh); end
    step();
  endtask

  task automatic test_collision();
    // Dwell is 0 here; three enabled cycles bring it to expiry.
    i_auto_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL coll_pre: got refresh=%b required 0", o_refresh); end
    end
    step();
    i_next = 1'b1;
    page_m = (page_m + 1) % 8;
    exp_q.push_back(make_exp(blk_m, page_m, cnt_m));
    step();
    i_next = 1'b0; i_auto_en = 1'b0;
    n_cmp++; if (o_page !== 3'(page_m)) begin n_bad++; $display("FAIL coll_single_advance: got page=%0d required %0d", o_page, page_m); end
    step();
    n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL coll_single_refresh: got %b required 0", o_refresh); end
    // i_next with a handshake: the new block wins.
    i_next = 1'b1; bus.i_block = BLK_B; bus.i_block_valid = 1'b1;
    cnt_m = cnt_m + 32'd1; blk_m = BLK_B; page_m = 0;
    exp_q.push_back(make_exp(BLK_B, 0, cnt_m));
    step();
    i_next = 1'b0; bus.i_block_valid = 1'b0;
    n_cmp++; if (o_page !== 3'd0) begin n_bad++; $display("FAIL coll_hs_page: got %0d required 0", o_page); end
    n_cmp++; if (o_count !== cnt_m) begin n_bad++; $display("FAIL coll_hs_count: got %h required %h", o_count, cnt_m); end
    step();
  endtask

  task automatic test_back_to_back();
    bus.i_block = BLK_C; bus.i_block_valid = 1'b1;
    cnt_m = cnt_m + 32'd1; blk_m = BLK_C; page_m = 0;
    exp_q.push_back(make_exp(BLK_C, 0, cnt_m));
    step();
    bus.i_block = BLK_A;
    n_cmp++; if (bus.o_block_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_load: got %b required 0", bus.o_block_ready); end
    step();
    n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got refresh=%b required 0", o_refresh); end
    n_cmp++; if (o_data !== page_word(BLK_C, 0)) begin n_bad++; $display("FAIL b2b_hold: got %h required %h", o_data, page_word(BLK_C, 0)); end
    cnt_m = cnt_m + 32'd1; blk_m = BLK_A;
    exp_q.push_back(make_exp(BLK_A, 0, cnt_m));
    step();
    bus.i_block_valid = 1'b0;
    n_cmp++; if (o_count !== cnt_m) begin n_bad++; $display("FAIL b2b_count: got %h required %h", o_count, cnt_m); end
    step();
  endtask

  task automatic test_clr_show();
    test_manual(5);
    n_cmp++; if (o_page !== 3'd5) begin n_bad++; $display("FAIL clr_setup_page: got %0d required 5", o_page); end
    clr = 1'b1; i_next = 1'b1; bus.i_block = BLK_B; bus.i_block_valid = 1'b1;
    step();
    clr = 1'b0; i_next = 1'b0; bus.i_block_valid = 1'b0;
    cnt_m = 32'd0; page_m = 0; blk_m = '0;
    n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL clr_refresh: got %b required 0", o_refresh); end
    n_cmp++; if (o_page !== 3'd0) begin n_bad++; $display("FAIL clr_page: got %0d required 0", o_page); end
    n_cmp++; if (o_data !== 16'h0000) begin n_bad++; $display("FAIL clr_data: got %h required 0000", o_data); end
    n_cmp++; if (o_count !== 32'd0) begin n_bad++; $display("FAIL clr_count: got %h required 0", o_count); end
    n_cmp++; if (bus.o_block_ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready: got %b required 1", bus.o_block_ready); end
    step();
    n_cmp++; if (o_refresh !== 1'b0) begin n_bad++; $display("FAIL clr_no_pulse: got %b required 0", o_refresh); end
  endtask

  task automatic test_count_wrap();
    test_load(BLK_A);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    step();
    cnt_m = 32'hFFFF_FFFF;
    n_cmp++; if (o_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h required ffffffff", o_count); end
    test_load(BLK_C);
    n_cmp++; if (o_count !== 32'd0) begin n_bad++; $display("FAIL wrap_zero: got %h required 0", o_count); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load(BLK_A);
    test_manual(8);
    n_cmp++; if (o_data !== 16'h0011 || o_page !== 3'd0) begin n_bad++; $display("FAIL manual_wrap: got data=%h page=%0d required 0011 page 0", o_data, o_page); end
    test_auto();
    test_collision();
    test_back_to_back();
    test_clr_show();
    test_count_wrap();
    step(); step();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d pending refreshes required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_display_pager.md
AES_DISPLAY_PAGER -- requirements
Module: aes_display_pager

Interface
REQ-001 Parameter: DWELL_CYCLES, default 100_000_000, clock cycles each page stays shown in auto mode (legal range 2..2^32-1).
REQ-002 Port: clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 Port: clr  input  1  reset, synchronous, active-high.
REQ-004 Port: i_block  input  [0:127]  AES result block; bit 0 is the MSB.
REQ-005 Port: i_block_valid  input  1  i_block is valid this cycle.
REQ-006 Port: o_block_ready  output  1  pager can accept a block this cycle.
REQ-007 Port: i_next  input  1  single-cycle, pre-debounced request to advance one page.
REQ-008 Port: i_auto_en  input  1  enables timed auto-advance.
REQ-009 Port: o_data  output  [0:15]  current 16-bit page, to the display's i_data.
REQ-010 Port: o_refresh  output  1  one-cycle pulse telling the display to latch o_data.
REQ-011 Port: o_page  output  [2:0]  index of the page currently shown.
REQ-012 Port: o_count  output  [0:31]  number of blocks accepted, to the display's i_count.

Function
REQ-013 Block shall hold one 128-bit page buffer; page p is buffer bits [16p : 16p+15]; o_data shall be page o_page of the buffer.
REQ-014 FSM states shall be IDLE (no block held), LOAD (buffer written, refresh pending) and SHOW (page held).
REQ-015 o_block_ready shall be 1 in IDLE and SHOW and 0 in LOAD.
REQ-016 A handshake (i_block_valid & o_block_ready) shall write i_block to the buffer, set o_page=0, clear the dwell counter, increment o_count (mod 2^32) and enter LOAD.
REQ-017 LOAD shall last exactly one cycle, assert o_refresh for that cycle, then go to SHOW.
REQ-018 In SHOW, an advance event shall occur on i_next=1, or when i_auto_en=1 and the dwell counter reaches DWELL_CYCLES-1.
REQ-019 Each advance event shall set o_page to (o_page+1) mod 8 (7 wraps to 0), clear the dwell counter, and pulse o_refresh on the next cycle, so new o_data and o_refresh appear together.
REQ-020 The dwell counter shall increment each SHOW cycle only while i_auto_en=1; it shall hold when i_auto_en=0 and clear on any advance or handshake.
REQ-021 i_next and dwell expiry in the same cycle shall advance by exactly one page.
REQ-022 A handshake in the same cycle as an advance event shall take priority; the advance is dropped and o_page becomes 0.
REQ-023 In IDLE, i_next and the auto timer shall be ignored, o_refresh shall stay 0 and o_data shall read 16'h0000.
REQ-024 o_refresh shall never be high on two consecutive cycles unless separate events cause it.
REQ-025 o_refresh latency shall be 1 cycle from handshake and 1 cycle from advance event.

Reset
REQ-026 With clr=1 at a clk edge, the block shall enter IDLE and clear buffer, o_page, dwell counter and o_count to 0; o_refresh shall be 0 and o_block_ready 1 on the next cycle.
REQ-027 clr shall override every simultaneous event, including a handshake; a reset during LOAD or SHOW shall drop the held block with no o_refresh pulse.
REQ-028 Outputs after reset: o_data=0, o_page=0, o_count=0, o_refresh=0, o_block_ready=1.

Verification
REQ-029 Load: reset, then a handshake with i_block=128'h00112233_44556677_8899AABB_CCDDEEFF -> next cycle o_refresh=1, o_data=16'h0011, o_page=0, o_count=1, o_block_ready=0; the cycle after, o_refresh=0 and o_block_ready=1.
REQ-030 Manual paging: same block, pulse i_next 8 times -> o_data steps 2233, 4455, ..., EEFF and then wraps to 0011 with o_page=0; each step gives exactly one o_refresh.
REQ-031 Auto paging: DWELL_CYCLES=4, i_auto_en=1 -> one advance every 4 SHOW cycles; dropping i_auto_en for 10 cycles freezes the counter and resumes it with no lost count.
REQ-032 Collisions: i_next together with dwell expiry -> one advance only; i_next together with a new handshake -> o_page=0 and the new block's page 0 is shown, o_count increments.
REQ-033 Idle and reset: i_next or auto before any block -> no o_refresh and o_data=0; clr asserted mid-SHOW at o_page=5 -> IDLE, all outputs at reset values, no o_refresh.
REQ-034 o_count wrap: preload-free run of handshakes shall be checked with a forced o_count of 32'hFFFFFFFF -> next handshake gives 0.
